// File: rtl/ex13_pkg.sv
// Shared constants and types for the EX_13 forward path and its inverse.
// Holds the offset, the operand widths and the divider FSM states.
package ex13_pkg;

    localparam int G_W = 16;
    localparam int B_W = 8;

    localparam logic [G_W-1:0] OFFSET = 16'h004E;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ex13_unpack_div_step.sv
// One restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and emit the quotient bit.
module div_step
    import ex13_pkg::*;
(
    input  logic [B_W:0]   pr,
    input  logic           d_msb,
    input  logic [B_W-1:0] b,
    output logic [B_W:0]   pr_next,
    output logic           q_bit
);

    logic [B_W:0] pr_shift;

    assign pr_shift = {pr[B_W-1:0], d_msb};

    // Trial subtraction; keep the shifted value when the divisor does not fit.
    always_comb begin
        pr_next = pr_shift;
        q_bit   = 1'b0;
        if (pr_shift >= {1'b0, b}) begin
            pr_next = pr_shift - {1'b0, b};
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/ex13_unpack_div.sv
// Inverse of EX_13: strips the offset from g and divides by b, one
// quotient bit per clock, with ready/valid handshakes on both sides.
module ex13_unpack_div
    import ex13_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [G_W-1:0] g,
    input  logic [B_W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [G_W-1:0] q,
    output logic [B_W-1:0] r,
    output logic           err_under,
    output logic           err_div0
);

    state_t state, state_n;

    logic [G_W-1:0] d;
    logic [B_W-1:0] bv;
    logic [B_W:0]   pr;
    logic [3:0]     cnt;

    logic [G_W:0]   diff;
    logic           under;
    logic           div0;
    logic [B_W:0]   pr_next;
    logic           q_bit;
    logic           accept;
    logic           xfer;
    logic           last;

    assign diff   = {1'b0, d} - {1'b0, OFFSET};
    assign under  = diff[G_W];
    assign div0   = (bv == '0);
    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;
    assign last   = (cnt == 4'hF);

    div_step u_step (
        .pr      (pr),
        .d_msb   (d[G_W-1]),
        .b       (bv),
        .pr_next (pr_next),
        .q_bit   (q_bit)
    );

    // Next-state decode.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = SUB;
            SUB:  state_n = (under || div0) ? DONE : DIV;
            DIV:  if (last) state_n = DONE;
            DONE: if (xfer) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Datapath: d holds g, then the dividend, and finally fills with
    // quotient bits from the bottom as dividend bits leave the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d   <= '0;
            bv  <= '0;
            pr  <= '0;
            cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        d  <= g;
                        bv <= b;
                    end
                end
                SUB: begin
                    d   <= diff[G_W-1:0];
                    pr  <= '0;
                    cnt <= '0;
                end
                DIV: begin
                    d   <= {d[G_W-2:0], q_bit};
                    pr  <= pr_next;
                    cnt <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs. Error results enter DONE one cycle before
    // out_valid rises, so both paths present valid from a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            err_under <= 1'b0;
            err_div0  <= 1'b0;
        end else begin
            in_ready <= (state_n == IDLE);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        q         <= '0;
                        r         <= '0;
                        err_under <= 1'b0;
                        err_div0  <= 1'b0;
                    end
                end
                SUB: begin
                    if (under) begin
                        err_under <= 1'b1;
                        q         <= '0;
                        r         <= '0;
                    end else if (div0) begin
                        err_div0  <= 1'b1;
                        q         <= '1;
                        r         <= '0;
                    end
                end
                DIV: begin
                    if (last) begin
                        q         <= {d[G_W-2:0], q_bit};
                        r         <= pr_next[B_W-1:0];
                        out_valid <= 1'b1;
                    end
                end
                DONE: out_valid <= !xfer;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex13_unpack_div.sv
// Randomised scoreboard bench for ex13_unpack_div.
// A driver pushes expected results; a monitor pops and compares.
module tb_ex13_unpack_div;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] g = '0;
    logic [7:0]  b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] q;
    logic [7:0]  r;
    logic        err_under;
    logic        err_div0;

    ex13_unpack_div dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g         (g),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .err_under (err_under),
        .err_div0  (err_div0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        eu;
        logic        ed;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int hold_req = 0;
    int hold_left = 0;
    int last_xfer = -1;
    int last_acc = 0;
    bit seen = 0;
    logic [15:0] hq;
    logic [7:0]  hr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] gg,
                                   input logic [7:0] bb, input int acc);
        exp_t x;
        int dv;
        x.acc = acc;
        x.eu  = 1'b0;
        x.ed  = 1'b0;
        if (int'(gg) < 78) begin
            x.q = 16'h0000; x.r = 8'h00; x.eu = 1'b1; x.lat = 2;
        end else if (bb == 8'h00) begin
            x.q = 16'hFFFF; x.r = 8'h00; x.ed = 1'b1; x.lat = 2;
        end else begin
            dv    = int'(gg) - 78;
            x.q   = 16'(dv / int'(bb));
            x.r   = 8'(dv % int'(bb));
            x.lat = 17;
        end
        return x;
    endfunction

    task automatic issue(input logic [15:0] gg, input logic [7:0] bb);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        g = gg;
        b = bb;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        last_acc = cyc + 1;
        sb.push_back(model(gg, bb, cyc + 1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Monitor: compare on first sight of out_valid, then watch stability.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) begin
                chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                if (!seen) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", {31'd0, out_valid}, 32'd0);
                    end else begin
                        e = sb[0];
                        chk("latency", cyc - e.acc, e.lat);
                        chk("q", {16'd0, q}, {16'd0, e.q});
                        chk("r", {24'd0, r}, {24'd0, e.r});
                        chk("err_under", {31'd0, err_under}, {31'd0, e.eu});
                        chk("err_div0", {31'd0, err_div0}, {31'd0, e.ed});
                    end
                    seen = 1;
                    hq = q;
                    hr = r;
                    hold_left = hold_req;
                    hold_req = 0;
                end else begin
                    chk("hold_q", {16'd0, q}, {16'd0, hq});
                    chk("hold_r", {24'd0, r}, {24'd0, hr});
                end
                if (hold_left > 0) begin
                    out_ready = 1'b0;
                    hold_left--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    seen = 0;
                    last_xfer = cyc + 1;
                end
            end else begin
                if (seen) chk("valid_drop", {31'd0, out_valid}, 32'd1);
                out_ready = 1'(($urandom_range(0, 1)));
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({nm, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({nm, "_q"}, {16'd0, q}, 32'd0);
        chk({nm, "_r"}, {24'd0, r}, 32'd0);
        chk({nm, "_flags"}, {30'd0, err_under, err_div0}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b1;
        #1 chk("rdy_pre", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rdy_post", {31'd0, in_ready}, 32'd1);

        issue(16'h03F6, 8'h34);
        issue(16'h0100, 8'h07);
        issue(16'hFFFF, 8'h01);
        issue(16'h004E, 8'hFF);
        issue(16'h004D, 8'h05);
        issue(16'h1000, 8'h00);
        issue(16'h0000, 8'h00);
        drain();

        hold_req = 5;
        issue(16'h1234, 8'h09);
        issue(16'h0800, 8'h11);
        chk("b2b_accept", last_acc, last_xfer + 1);
        drain();

        issue(16'h4000, 8'h03);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1 chk_zero("mid_rst");
        sb.delete();
        seen = 0;
        repeat (3) @(negedge clk);
        chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b1;
        #1 chk("rdy_pre2", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_stale_out", {31'd0, out_valid}, 32'd0);
            if (i == 0) chk("rdy_post2", {31'd0, in_ready}, 32'd1);
        end
        issue(16'h4000, 8'h03);
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [15:0] gg;
            logic [7:0]  bb;
            gg = 16'($urandom);
            bb = 8'($urandom);
            if ($urandom_range(0, 9) == 0) gg = 16'($urandom_range(0, 90));
            if ($urandom_range(0, 9) == 0) bb = 8'($urandom_range(0, 1));
            issue(gg, bb);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex13_unpack_div.md
# ex13_unpack_div

Sequential inverse of the EX_13 multiply-offset pipeline, which produces g = a*b + 16'h004E. Given a result word g and the known multiplier b, this block removes the offset and divides by b to recover the original operand a, plus a remainder. The remainder is non-zero only if g was not produced by the forward pipeline. It sits on the consumer side of EX_13 results, with ready/valid handshakes on both ends. Division is a 16-iteration restoring divider, one quotient bit per clock.

## Interface
- OFFSET, 16'h004E: constant that the forward path added, removed before dividing.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  g/b operands valid.
- in_ready  output  1  block can accept operands.
- g  input  16  result word to invert.
- b  input  8  divisor (original multiplier operand).
- out_valid  output  1  q/r/flags valid.
- out_ready  input  1  downstream accepts the result.
- q  output  16  quotient, (g − OFFSET) / b.
- r  output  8  remainder, (g − OFFSET) mod b.
- err_under  output  1  g < OFFSET.
- err_div0  output  1  b == 0.

## Operation
- FSM states: IDLE, SUB, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch g and b, go to SUB.
- SUB:
  - Compute dividend d = g − OFFSET as a 17-bit subtraction.
  - If g < OFFSET: set err_under, q=0, r=0, go to DONE.
  - Else if b == 0: set err_div0, q=16'hFFFF, r=8'h00, go to DONE.
  - err_under takes priority when both conditions hold.
  - Otherwise: clear the partial remainder (9-bit) and the 4-bit count, go to DIV.
- DIV, each cycle:
  - pr' = {pr[7:0], d[15]}.
  - d is shifted left by one.
  - If pr' ≥ {1'b0,b}: pr = pr' − b, shift 1 into the quotient.
  - Else: pr = pr', shift 0 into the quotient.
  - count increments; after the 16th step go to DONE.
- DONE:
  - out_valid=1; q, r and the flags are held stable.
  - On out_ready: go to IDLE.
- Width rules: quotient is 16 bits and cannot overflow for b ≥ 1. The remainder is always < b and fits in 8 bits. No saturation.
- Only one transaction is in flight. in_ready=0 in SUB, DIV and DONE.
- Reset, including mid-operation, forces:
  - State IDLE; all outputs 0; in_ready=0.
  - The datapath registers cleared.
  - Any in-flight operation is discarded with no result.
  - in_ready registers to 1 on the first clk edge after reset deasserts.

## Timing
- The accepting edge is N.
- Normal path: SUB during cycle N→N+1, DIV on edges N+2 … N+17, out_valid high after edge N+17. Latency is 17 cycles.
- Error path: out_valid high after edge N+2.
- Output transfer on the edge where out_valid && out_ready. in_ready rises after that same edge. Back-to-back issue is possible one cycle later.
- out_valid is never deasserted without a transfer. Outputs are registered, with no combinational in→out paths.

## Structure
- Package ex13_pkg holds:
  - the OFFSET constant (shared with EX_13);
  - the state enum {IDLE, SUB, DIV, DONE};
  - the width localparams (G_W=16, B_W=8).
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: pr (9b), d_msb, b.
  - Outputs: pr_next (9b), q_bit.
  - Instantiated once in the DIV datapath.

## Test plan
- Nominal exact case:
  - g=16'h03F6, b=8'h34 (from a=8'h12) -> q=16'h0012, r=8'h00, no flags.
  - out_valid exactly 17 cycles after accept.
- Non-exact case: g=16'h0100, b=8'h07 -> q=16'h0019, r=8'h03.
- Boundaries:
  - g=16'hFFFF, b=8'h01 -> q=16'hFFB1, r=0.
  - g=16'h004E, b=8'hFF -> q=0, r=0, no flags.
- Errors:
  - g=16'h004D, b=8'h05 -> err_under=1, q=0, r=0.
  - g=16'h1000, b=8'h00 -> err_div0=1, q=16'hFFFF, r=0.
  - g=16'h0000, b=8'h00 -> err_under=1 only.
  - Each error result arrives 2 cycles after accept.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, q, r stable, in_ready=0.
  - Release -> transfer, next operand accepted on the following edge.
- Reset mid-DIV:
  - Assert reset at step 8 -> all outputs 0 immediately, no out_valid afterward.
  - After release, in_ready=1 on the next edge; a fresh operation computes correctly.
